// File: rtl/vfifo_pkg.sv
// rtl/vfifo_pkg.sv - shared pointer width, pointer type and modular pointer-difference helper
package vfifo_pkg;

   // Default geometry; instances with other ADDR_WIDTH values derive their
   // own pointer width through vfifo_ptr_width().
   localparam int VFIFO_ADDR_WIDTH = 8;
   localparam int VFIFO_PTR_WIDTH  = VFIFO_ADDR_WIDTH + 1;

   typedef logic [VFIFO_PTR_WIDTH-1:0] vfifo_ptr_t;

   // Pointers carry one extra wrap bit above the RAM address.
   function automatic int vfifo_ptr_width(input int addr_width);
      return addr_width + 1;
   endfunction

   // a - b modulo 2^ptr_width; shared by the read and write controllers so
   // both sides agree on occupancy arithmetic across the wrap.
   function automatic logic [31:0] vfifo_ptr_diff(input logic [31:0] a,
                                                  input logic [31:0] b,
                                                  input int unsigned ptr_width);
      logic [31:0] mask;
      mask = (32'd1 << ptr_width) - 32'd1;
      return (a - b) & mask;
   endfunction

endpackage

// File: rtl/vfifo_rd_skid.sv
// rtl/vfifo_rd_skid.sv - 2-entry FIFO output buffer holding the head word in a register
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   push, push_data  write one word (caller guarantees no overflow)
//   pop              remove the head word (ignored when empty)
//   head             oldest word, taken directly from a register
//   valid            head word present
//   count            entries held, 0..2
module vfifo_rd_skid
   import vfifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output logic                  valid,
   output logic [1:0]            count
);

   // d0 is always the head so the output needs no read mux; d1 shifts into
   // d0 when the head is consumed with a second word waiting.
   logic [DATA_WIDTH-1:0] d0;
   logic [DATA_WIDTH-1:0] d1;
   logic [1:0]            cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         d0  <= '0;
         d1  <= '0;
         cnt <= 2'd0;
      end else begin
         unique case (cnt)
            2'd0: begin
               if (push) begin
                  d0  <= push_data;
                  cnt <= 2'd1;
               end
            end
            2'd1: begin
               if (push && pop) begin
                  d0 <= push_data;
               end else if (push) begin
                  d1  <= push_data;
                  cnt <= 2'd2;
               end else if (pop) begin
                  cnt <= 2'd0;
               end
            end
            default: begin
               if (pop) begin
                  d0 <= d1;
                  if (push) begin
                     d1 <= push_data;
                  end else begin
                     cnt <= 2'd1;
                  end
               end
            end
         endcase
      end
   end

   assign head  = d0;
   assign valid = (cnt != 2'd0);
   assign count = cnt;

endmodule

// File: rtl/vfifo_rd_stream.sv
// rtl/vfifo_rd_stream.sv - FIFO read-side controller: RAM port-B fetch, latency absorption, output stream
//
// Optional feature macro: VFIFO_RD_LEVEL_EN adds the level port.
//
// Ports:
//   clk, rst_n   clock shared with RAM and writer, synchronous active-low reset
//   wr_ptr       writer's binary pointer (MSB is the wrap bit)
//   rd_ptr       consumed pointer returned to the writer for full detection
//   adr_b        RAM port-B read address
//   q_b          RAM port-B data, valid the cycle after adr_b is captured
//   dout         head word
//   dout_valid   head word present
//   dout_ready   consumer accepts the head word
//   level        wr_ptr - rd_ptr (only with VFIFO_RD_LEVEL_EN)
module vfifo_rd_stream
   import vfifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH:0]   wr_ptr,
   output logic [ADDR_WIDTH:0]   rd_ptr,
   output logic [ADDR_WIDTH-1:0] adr_b,
   input  logic [DATA_WIDTH-1:0] q_b,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready
`ifdef VFIFO_RD_LEVEL_EN
   ,
   output logic [ADDR_WIDTH:0]   level
`endif
);

   localparam int PW = vfifo_ptr_width(ADDR_WIDTH);

   logic [PW-1:0] fptr;
   logic [PW-1:0] rd_ptr_q;
   logic          in_flight;
   logic [1:0]    skid_count;
   logic [1:0]    occ;
   logic          fetch_empty;
   logic          pop;
   logic          issue;

   assign fetch_empty = (fptr == wr_ptr);
   assign pop         = dout_valid & dout_ready;
   // A read in flight already owns a buffer slot, so it counts toward occ.
   assign occ         = skid_count + {1'b0, in_flight};
   // A pop this edge frees a slot, which lets a full pipeline keep issuing
   // and sustain one word per cycle.
   assign issue       = !fetch_empty && ((occ < 2'd2) || pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fptr      <= '0;
         rd_ptr_q  <= '0;
         in_flight <= 1'b0;
      end else begin
         if (issue) begin
            fptr <= fptr + 1'b1;
         end
         in_flight <= issue;
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   vfifo_rd_skid #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (in_flight),
      .push_data (q_b),
      .pop       (pop),
      .head      (dout),
      .valid     (dout_valid),
      .count     (skid_count)
   );

   assign adr_b  = fptr[ADDR_WIDTH-1:0];
   assign rd_ptr = rd_ptr_q;

`ifdef VFIFO_RD_LEVEL_EN
   assign level = PW'(vfifo_ptr_diff(32'(wr_ptr), 32'(rd_ptr_q), PW));
`endif

endmodule

// File: tb/tb_vfifo_rd_stream.sv
// tb/tb_vfifo_rd_stream.sv - scoreboard bench for vfifo_rd_stream at ADDR_WIDTH 8 and 3
module tb_vfifo_rd_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic [8:0]  wr8;
   logic [8:0]  rd8;
   logic [7:0]  adr8;
   logic [31:0] q8;
   logic [31:0] dout8;
   logic        v8;
   logic        rdy8;
   logic [31:0] ram8 [0:255];

   logic [3:0]  wr3;
   logic [3:0]  rd3;
   logic [2:0]  adr3;
   logic [31:0] q3;
   logic [31:0] dout3;
   logic        v3;
   logic        rdy3;
   logic [31:0] ram3 [0:7];

`ifdef VFIFO_RD_LEVEL_EN
   logic [8:0]  lvl8;
   logic [3:0]  lvl3;
`endif

   always @(posedge clk) begin
      q8 <= ram8[adr8];
      q3 <= ram3[adr3];
   end

   vfifo_rd_stream #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut8 (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_ptr     (wr8),
      .rd_ptr     (rd8),
      .adr_b      (adr8),
      .q_b        (q8),
      .dout       (dout8),
      .dout_valid (v8),
      .dout_ready (rdy8)
`ifdef VFIFO_RD_LEVEL_EN
      ,
      .level      (lvl8)
`endif
   );

   vfifo_rd_stream #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut3 (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_ptr     (wr3),
      .rd_ptr     (rd3),
      .adr_b      (adr3),
      .q_b        (q3),
      .dout       (dout3),
      .dout_valid (v3),
      .dout_ready (rdy3)
`ifdef VFIFO_RD_LEVEL_EN
      ,
      .level      (lvl3)
`endif
   );

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp8 [$];
   logic [31:0] exp3 [$];
   int          cons3;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge with inputs settled: a handshake visible now
   // completes at the coming posedge, so the scoreboard is popped here.
   task automatic tick();
      if (rst_n && v8 && rdy8) begin
         if (exp8.size() == 0) chk("sb8_empty", 64'(exp8.size()), 64'd1);
         else                  chk("sb8_data", 64'(dout8), 64'(exp8.pop_front()));
      end
      if (rst_n && v3 && rdy3) begin
         cons3++;
         if (exp3.size() == 0) chk("sb3_empty", 64'(exp3.size()), 64'd1);
         else                  chk("sb3_data", 64'(dout3), 64'(exp3.pop_front()));
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic write8(input logic [31:0] d);
      ram8[wr8[7:0]] = d;
      exp8.push_back(d);
      wr8 = wr8 + 9'd1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      rdy8  = 1'b1;
      rdy3  = 1'b1;
      wr8   = '0;
      wr3   = '0;
      exp8.delete();
      exp3.delete();
      cons3 = 0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [2:0] adrs [$];
      int         nw;
      int         occ3;

      rst_n = 1'b0;
      rdy8  = 1'b1;
      rdy3  = 1'b1;
      wr8   = '0;
      wr3   = '0;
      cons3 = 0;
      for (int i = 0; i < 256; i++) ram8[i] = '0;
      for (int i = 0; i < 8; i++)   ram3[i] = '0;
      @(negedge clk);

      // reset
      do_reset();
      chk("rst_rd_ptr", 64'(rd8), 64'd0);
      chk("rst_valid", 64'(v8), 64'd0);
      chk("rst_dout", 64'(dout8), 64'd0);
      chk("rst_adr_b", 64'(adr8), 64'd0);
`ifdef VFIFO_RD_LEVEL_EN
      chk("rst_level", 64'(lvl8), 64'd0);
`endif

      // single word and first-word latency
      rdy8 = 1'b0;
      write8(32'hA5A5_0001);
      chk("single_adr_b", 64'(adr8), 64'd0);
      chk("single_valid_n0", 64'(v8), 64'd0);
      tick();
      chk("single_valid_n1", 64'(v8), 64'd0);
      chk("single_adr_after_issue", 64'(adr8), 64'd1);
      tick();
      chk("single_valid_n2", 64'(v8), 64'd1);
      chk("single_dout", 64'(dout8), 64'hA5A5_0001);
      rdy8 = 1'b1;
      tick();
      chk("single_valid_after_pop", 64'(v8), 64'd0);
      chk("single_rd_ptr", 64'(rd8), 64'd1);

      // streaming without bubbles
      do_reset();
      rdy8 = 1'b0;
      for (int i = 0; i < 16; i++) write8(32'(i));
      tick();
      tick();
      tick();
      rdy8 = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("stream_valid", 64'(v8), 64'd1);
         tick();
      end
      chk("stream_rd_ptr", 64'(rd8), 64'd16);
      chk("stream_valid_end", 64'(v8), 64'd0);
      chk("stream_sb_left", 64'(exp8.size()), 64'd0);

      // backpressure
      do_reset();
      rdy8 = 1'b0;
      for (int i = 0; i < 10; i++) write8(32'h100 + 32'(i));
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i == 4) chk("bp_dout_early", 64'(dout8), 64'h100);
      end
      chk("bp_adr_b", 64'(adr8), 64'd2);
      chk("bp_valid", 64'(v8), 64'd1);
      chk("bp_dout_late", 64'(dout8), 64'h100);
`ifdef VFIFO_RD_LEVEL_EN
      chk("bp_level", 64'(lvl8), 64'd10);
`endif
      rdy8 = 1'b1;
      for (int i = 0; i < 40 && exp8.size() > 0; i++) tick();
      chk("bp_drain", 64'(exp8.size()), 64'd0);
      chk("bp_rd_ptr", 64'(rd8), 64'd10);

      // wrap-around on the 8-deep instance
      do_reset();
      rdy3 = 1'b0;
      nw   = 0;
      adrs.delete();
      for (int cyc = 0; cyc < 300 && cons3 < 20; cyc++) begin
         if (cyc == 12) rdy3 = 1'b1;
         occ3 = int'(4'(wr3 - 4'(cons3)));
`ifdef VFIFO_RD_LEVEL_EN
         if (occ3 == 8) chk("wrap_level_full", 64'(lvl3), 64'd8);
`endif
         if (adrs.size() == 0 || adr3 != adrs[$]) adrs.push_back(adr3);
         if (occ3 < 8 && nw < 20) begin
            ram3[wr3[2:0]] = 32'h300 + 32'(nw);
            exp3.push_back(32'h300 + 32'(nw));
            wr3 = wr3 + 4'd1;
            nw++;
         end
         tick();
      end
      if (adrs.size() == 0 || adr3 != adrs[$]) adrs.push_back(adr3);
      chk("wrap_consumed", 64'(cons3), 64'd20);
      chk("wrap_rd_ptr", 64'(rd3), 64'd4);
      chk("wrap_adr_count", 64'(adrs.size()), 64'd21);
      for (int k = 0; k < adrs.size(); k++) chk("wrap_adr_seq", 64'(adrs[k]), 64'(k % 8));
      rdy3 = 1'b0;

      // reset mid-stream
      do_reset();
      rdy8 = 1'b0;
      for (int i = 0; i < 5; i++) write8(32'h500 + 32'(i));
      tick();
      tick();
      tick();
      tick();
      chk("mid_valid_before", 64'(v8), 64'd1);
      rst_n = 1'b0;
      wr8   = '0;
      exp8.delete();
      tick();
      chk("mid_valid_after", 64'(v8), 64'd0);
      chk("mid_rd_ptr", 64'(rd8), 64'd0);
      rst_n = 1'b1;
      rdy8  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("mid_stale", 64'(v8), 64'd0);
         tick();
      end
      write8(32'hBEEF_0000);
      for (int i = 0; i < 10 && exp8.size() > 0; i++) tick();
      chk("mid_new_word", 64'(exp8.size()), 64'd0);
      chk("mid_rd_ptr_end", 64'(rd8), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vfifo_rd_stream.md
# vfifo_rd_stream

Read-side controller for the versatile FIFO. It owns port B of the single-clock simple dual-port RAM: it issues read addresses, absorbs the RAM's one-cycle read latency, and presents words to the consumer on a valid/ready stream at one word per cycle. It exports a consumed read pointer to the write-side controller for full detection.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; must match the RAM.
- ADDR_WIDTH, 8, RAM address width; FIFO depth is 2^ADDR_WIDTH.

Ports:
- clk  in  1  single clock, shared with the RAM and the write-side controller.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- wr_ptr  in  ADDR_WIDTH+1  binary write pointer (MSB is the wrap bit), registered by the writer.
- rd_ptr  out  ADDR_WIDTH+1  binary consumed pointer (words accepted by the consumer), registered.
- adr_b  out  ADDR_WIDTH  RAM port-B read address.
- q_b  in  DATA_WIDTH  RAM port-B data; valid the cycle after the address is captured.
- dout  out  DATA_WIDTH  head word, registered.
- dout_valid  out  1  head word present.
- dout_ready  in  1  consumer accepts the head word when dout_valid is also high.
- level  out  ADDR_WIDTH+1  occupancy, wr_ptr − rd_ptr (present only with VFIFO_RD_LEVEL_EN).

## Operation
- Internal fetch pointer fptr (ADDR_WIDTH+1): words issued to the RAM. adr_b = fptr[ADDR_WIDTH-1:0], combinational from the register.
- Fetch-empty: fptr == wr_ptr (all bits). Pointers wrap naturally modulo 2^(ADDR_WIDTH+1).
- 2-entry output buffer (skid). occ = buffered entries + reads in flight (0..2).
- pop = dout_valid & dout_ready.
- Issue a read at the edge when !fetch_empty & (occ < 2 | pop). On issue, fptr increments and one read is marked in flight.
- In-flight read completes the next cycle: q_b is written into the buffer at that edge.
- dout/dout_valid always reflect the oldest buffered entry. Buffer order is strictly FIFO.
- rd_ptr increments on each pop; it never passes fptr. The writer uses rd_ptr, not fptr, so a slot is not overwritten until its word has been consumed.
- Simultaneous pop, completion and issue in one cycle are legal; occ is updated as occ + issue − pop.
- Writer contract: wr_ptr never decreases modularly, and wr_ptr − rd_ptr ≤ 2^ADDR_WIDTH.
- Reset: fptr = 0, rd_ptr = 0, buffer empty, in-flight cleared, dout = 0, dout_valid = 0, level = 0.
- Reset mid-operation discards buffered and in-flight words. The writer shares rst_n and clears in the same edge.

## Timing
- Write at edge N makes wr_ptr advance in cycle N+1. The read issues at edge N+1, q_b is captured at edge N+2, and dout_valid is high in cycle N+2 (first-word latency of 2 edges after the pointer update).
- Sustained throughput is 1 word/cycle while dout_ready is held high and the FIFO stays non-empty.
- dout_ready low: at most 2 words are fetched ahead, then issue stalls. No word is lost or duplicated.
- dout_valid does not depend combinationally on dout_ready.

## Configuration
- VFIFO_RD_LEVEL_EN defined: the level port exists, combinational wr_ptr − rd_ptr (modulo 2^(ADDR_WIDTH+1)). Values range from 0 to 2^ADDR_WIDTH.
- VFIFO_RD_LEVEL_EN undefined: no level port and no subtractor. All other behaviour is identical.

## Structure
- Shared package vfifo_pkg holds the pointer width constant (ADDR_WIDTH+1) and the pointer type, plus the modular pointer-difference helper. The write-side controller uses the same helper.
- Sub-module vfifo_rd_skid implements the 2-entry buffer (push, pop, head, count). The top level holds fptr, rd_ptr, the in-flight flag and the issue logic.

## Test plan
- Reset: drive rst_n low for 2 cycles with dout_ready = 1 → rd_ptr = 0, dout_valid = 0, dout = 0, adr_b = 0, level = 0.
- Single word: ram[0] = 0xA5A5_0001, wr_ptr 0→1 at edge 10 → adr_b = 0 at edge 11, and from edge 12 dout = 0xA5A5_0001 with dout_valid = 1. After the pop, rd_ptr = 1 and dout_valid = 0.
- Streaming: 16 words with value = index are pre-written, dout_ready = 1 → 16 consecutive valid cycles with values 0..15 and no bubbles. Final rd_ptr = 16.
- Backpressure: 10 words written, dout_ready = 0 for 20 cycles → fptr = 2, dout holds word 0 stable, level = 10. Releasing dout_ready delivers words 0..9 in order.
- Wrap-around with ADDR_WIDTH = 3: push and pop 20 words → adr_b sequence 0..7,0..7,0..3 and rd_ptr = 20 mod 16 = 4. Data matches and level is 8 whenever the FIFO is full.
- Reset mid-stream: assert rst_n low while dout_valid = 1 with 2 words buffered → next cycle dout_valid = 0 and rd_ptr = 0, and no stale word is presented afterwards.
